// File: rtl/controle_ula_if.sv
// Request/result bundle between the control logic, the ALU result mux and controle_ula.
// The slave side is the sequencer; the master side is the requester plus the ALU.
interface controle_ula_if;
  logic       start;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] y_in;
  logic [3:0] opa;
  logic [3:0] opb;
  logic [2:0] sel;
  logic [7:0] resultado;
  logic       valido;
  logic       ocupado;
  logic       flag_zero;
  logic       erro;

  modport slave (
    input  start, op, a, b, y_in,
    output opa, opb, sel, resultado, valido, ocupado, flag_zero, erro
  );

  modport master (
    output start, op, a, b, y_in,
    input  opa, opb, sel, resultado, valido, ocupado, flag_zero, erro
  );
endinterface

// File: rtl/controle_ula.sv
// Sequencer for the ALU result mux: latches a request, waits the per-opcode
// settle time, then captures the mux output and reports completion flags.
module controle_ula #(
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 4
) (
  input logic           clk,
  input logic           rst,
  controle_ula_if.slave bus
);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, CAPTURA} state_e;

  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b111;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       erroPend_q;
  logic [3:0] opa_q;
  logic [3:0] opb_q;
  logic [2:0] sel_q;
  logic [7:0] resultado_q;
  logic       valido_q;
  logic       ocupado_q;
  logic       flagZero_q;
  logic       erro_q;

  logic [3:0] latency_d;
  logic       divZero_d;
  logic [7:0] captured_d;

  always_comb begin
    latency_d = 4'd0;
    if (bus.op == OP_MUL) latency_d = 4'(LAT_MUL);
    else if (bus.op == OP_DIV) latency_d = 4'(LAT_DIV);
  end

  // A divide by zero skips the divider wait and reports a saturated result.
  assign divZero_d  = (bus.op == OP_DIV) && (bus.b == 4'd0);
  assign captured_d = erroPend_q ? 8'hFF : bus.y_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OCIOSO;
      cnt_q       <= 4'd0;
      erroPend_q  <= 1'b0;
      opa_q       <= 4'd0;
      opb_q       <= 4'd0;
      sel_q       <= 3'd0;
      resultado_q <= 8'd0;
      valido_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      flagZero_q  <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      valido_q <= 1'b0;
      case (state_q)
        OCIOSO: begin
          if (bus.start) begin
            opa_q     <= bus.a;
            opb_q     <= bus.b;
            sel_q     <= bus.op;
            ocupado_q <= 1'b1;
            if (divZero_d) begin
              erroPend_q <= 1'b1;
              cnt_q      <= 4'd0;
              state_q    <= CAPTURA;
            end else begin
              erroPend_q <= 1'b0;
              cnt_q      <= latency_d;
              state_q    <= EXECUTA;
            end
          end
        end
        EXECUTA: begin
          if (cnt_q == 4'd0) state_q <= CAPTURA;
          else cnt_q <= cnt_q - 4'd1;
        end
        CAPTURA: begin
          resultado_q <= captured_d;
          flagZero_q  <= (captured_d == 8'd0);
          erro_q      <= erroPend_q;
          valido_q    <= 1'b1;
          ocupado_q   <= 1'b0;
          state_q     <= OCIOSO;
        end
        default: begin
          state_q   <= OCIOSO;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.opa       = opa_q;
  assign bus.opb       = opb_q;
  assign bus.sel       = sel_q;
  assign bus.resultado = resultado_q;
  assign bus.valido    = valido_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.flag_zero = flagZero_q;
  assign bus.erro      = erro_q;

endmodule
